// File: rtl/fp_result_fifo.sv
// fp_result_fifo: first-word-fall-through FIFO for FP converter results.
// Define FP_RESULT_FIFO_DECODE_EN to decode the head word to out_value.
module fp_result_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_s,
  input  logic [2:0]  in_e,
  input  logic [3:0]  in_f,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_s,
  output logic [2:0]  out_e,
  output logic [3:0]  out_f,
  output logic [11:0] out_value,
  output logic [4:0]  count,
  output logic [7:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  assign in_ready  = count != 5'(DEPTH);
  assign out_valid = count != 5'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head = out_valid ? mem[rptr] : 8'd0;
  assign {out_s, out_e, out_f} = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= 5'd0;
      drop_cnt <= 8'd0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (in_valid && !in_ready && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Storage is only visible through head, which is masked when empty.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {in_s, in_e, in_f};
  end

`ifdef FP_RESULT_FIFO_DECODE_EN
  logic [11:0] mag;
  assign mag       = {8'd0, out_f} << out_e;
  assign out_value = out_s ? (12'd0 - mag) : mag;
`else
  assign out_value = 12'd0;
`endif

endmodule

// File: tb/tb_fp_result_fifo.sv
// tb_fp_result_fifo: random and directed stimulus against a queue model.
// Honours FP_RESULT_FIFO_DECODE_EN for the expected out_value.
module tb_fp_result_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_s;
  logic [2:0]  in_e;
  logic [3:0]  in_f;
  logic        out_valid;
  logic        out_ready;
  logic        out_s;
  logic [2:0]  out_e;
  logic [3:0]  out_f;
  logic [11:0] out_value;
  logic [4:0]  count;
  logic [7:0]  drop_cnt;

  fp_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_e(in_e), .in_f(in_f),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_e(out_e), .out_f(out_f),
    .out_value(out_value), .count(count),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  int drops = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] dec(input logic [7:0] w);
    int m;
`ifdef FP_RESULT_FIFO_DECODE_EN
    m = int'(w[3:0]) * (1 << w[6:4]);
    if (w[7]) m = -m;
`else
    m = 0;
`endif
    return 12'(m);
  endfunction

  task automatic check_state();
    logic [7:0] h;
    h = (q.size() > 0) ? q[0] : 8'd0;
    chk("count", 32'(count), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    chk("drop_cnt", 32'(drop_cnt), 32'(drops));
    chk("head", 32'({out_s, out_e, out_f}), 32'(h));
    chk("out_value", 32'(out_value),
        32'((q.size() > 0) ? dec(h) : 12'd0));
  endtask

  // One clock: drive, check pre-edge state, advance the model.
  task automatic cycle(input bit v, input logic [7:0] w,
                       input bit r, input bit rs);
    bit do_push;
    bit do_pop;
    in_valid = v;
    {in_s, in_e, in_f} = w;
    out_ready = r;
    rst = rs;
    @(negedge clk);
    check_state();
    do_push = v && q.size() < DEPTH;
    do_pop = r && q.size() > 0;
    @(posedge clk);
    if (rs) begin
      q.delete();
      drops = 0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(w);
      if (v && !do_push && drops < 255) drops++;
    end
    #1;
  endtask

  function automatic logic [7:0] rw();
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    {in_s, in_e, in_f} = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    cycle(0, 8'd0, 0, 0);

    cycle(1, {1'b0, 3'd5, 4'd9}, 0, 0);
    cycle(1, {1'b1, 3'd0, 4'd1}, 0, 0);
    cycle(0, 8'd0, 0, 0);
    chk("head_288", 32'(out_value), 32'(dec({1'b0, 3'd5, 4'd9})));
    cycle(0, 8'd0, 1, 0);
    cycle(0, 8'd0, 1, 0);

    cycle(0, 8'd0, 0, 1);
    for (int i = 0; i < 10; i++) cycle(1, rw(), 0, 0);
    cycle(0, 8'd0, 0, 0);
    chk("full_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 8; i++) cycle(0, 8'd0, 1, 0);
    cycle(0, 8'd0, 0, 0);

    for (int i = 0; i < 3; i++) cycle(1, rw(), 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, rw(), 1, 0);
    cycle(0, 8'd0, 0, 0);
    chk("pp_count", 32'(count), 32'd3);

    for (int i = 0; i < 305; i++) cycle(1, rw(), 0, 0);
    cycle(0, 8'd0, 0, 0);
    chk("drop_sat", 32'(drop_cnt), 32'd255);

    cycle(0, 8'd0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, rw(), 0, 0);
    cycle(1, rw(), 1, 1);
    cycle(0, 8'd0, 0, 0);
    cycle(1, {1'b1, 3'd7, 4'd15}, 0, 0);
    cycle(0, 8'd0, 0, 0);
`ifdef FP_RESULT_FIFO_DECODE_EN
    chk("neg_1920", 32'(out_value), 32'h880);
`else
    chk("val_off", 32'(out_value), 32'h0);
`endif

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), rw(),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 199) == 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 8'd0, 1, 0);
    cycle(0, 8'd0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
